booth_multiplier: RTL and testbench
===================================

# booth_multiplier

Sequential radix-2 Booth multiplier for signed two's-complement operands. It sits directly downstream of the team's N-bit adder stage (RCA/CLA). It reuses that stage's add and subtract convention: subtract is `x + ~y` with `C_in = 1`. It issues one add/subtract plus one arithmetic shift per cycle and produces a full 2N-bit product. A single-operation start/ready/done handshake connects it to the sequencing logic above.

## Interface
Parameters:
- `N`, default 8: operand width in bits (N ≥ 2); the product is 2N bits.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `start`  input  1: request a multiply; sampled only while `ready` = 1.
- `multiplicand`  input  N: signed operand M; captured on accepted start.
- `multiplier`  input  N: signed operand Q; captured on accepted start.
- `ready`  output  1: high in IDLE only.
- `busy`  output  1: high in CALC only.
- `done`  output  1: one-cycle pulse, high in DONE only.
- `product`  output  2N: signed result; valid from the `done` cycle until the next accepted start.

## Operation
- States:
  - IDLE: on `start` = 1, load registers, go to CALC. Otherwise stay.
  - CALC: perform N iterations, then go to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- Registers:
  - Accumulator A: N+1 bits.
  - Q: N bits.
  - q_1: 1 bit.
  - M: N bits, sign-extended to N+1 bits when used.
  - Iteration counter: $clog2(N+1) bits.
  - `product` register: 2N bits.
- Load on accepted start:
  - A = 0, Q = `multiplier`, q_1 = 0, M = `multiplicand`, counter = N.
  - `product` is cleared to 0 at the same time.
- Each CALC cycle, decode {Q[0], q_1}:
  - 00 or 11: A unchanged.
  - 01: A = A + M (`C_in` = 0).
  - 10: A = A + ~M + 1 (`C_in` = 1).
- Then, in the same cycle, arithmetic shift right of {A, Q, q_1} by one, with A's MSB replicated. Decrement the counter.
- A is N+1 bits so that M = −2^(N−1) never overflows the accumulator. No overflow flag exists; the 2N-bit product is always exact.
- When the counter reaches 0 (after the N-th iteration), latch `product` = {A[N−1:0], Q} and go to DONE.
- `start` asserted in CALC or DONE is ignored; it is not queued.
- Operands may change freely after the accepted start edge.

## Timing
- Reset values (asynchronous, immediate):
  - State = IDLE; `ready` = 1, `busy` = 0, `done` = 0.
  - `product` = 0; A, Q, q_1, M and the counter = 0.
- Latency, with start accepted at edge 0:
  - CALC occupies cycles 1..N.
  - `done` = 1 and `product` valid during cycle N+1.
  - `ready` = 1 again from cycle N+2.
  - Throughput is one multiply per N+2 cycles.
- Outputs are registered or decoded from state only, with no combinational path from inputs.
- Reset asserted mid-CALC or in DONE:
  - Aborts immediately and discards the partial product.
  - `done` never pulses for the aborted operation.
  - After release, the block is in IDLE with `ready` = 1.
- `start` held high continuously: a new operation is accepted on each IDLE cycle, i.e. back-to-back every N+2 cycles.

## Test plan
All cases use N = 8.
- Reset: assert `rst` asynchronously between edges → `ready` = 1, `busy` = 0, `done` = 0, `product` = 0x0000 immediately.
- Mixed sign: M = 123, Q = −80 → `done` at cycle 9 after start, `product` = 0xD990 (−9840). Also M = −12, Q = 53 → 0xFD84 (−636).
- Extremes:
  - M = −128, Q = −128 → 0x4000 (16384).
  - M = 127, Q = 127 → 0x3F01 (16129).
  - M = −128, Q = 127 → 0xC080 (−16256).
- Zero and identity: M = 0, Q = −1 → 0x0000. M = −1, Q = 1 → 0xFFFF.
- Handshake:
  - Pulse `start` (M = 5, Q = 3) during CALC of a running 8 × 3 → ignored; first result 0x0018.
  - `busy` high exactly 8 cycles.
  - `done` high exactly 1 cycle.
  - `product` holds 0x0018 until the next accepted start.
- Reset mid-operation: start 123 × −80, assert `rst` in CALC cycle 4 → no `done` pulse, `product` = 0. A subsequent 2 × 1 completes with 0x0002 after N+1 cycles.

Source files
------------

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier for signed two's-complement operands.
// Latency: start accepted at edge 0, CALC in cycles 1..N, done/product in cycle N+1, ready in N+2.
// Backpressure: start is only sampled while ready=1; start in CALC/DONE is dropped, never queued.
//
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-high reset
//   start           - request a multiply (sampled in IDLE only)
//   multiplicand    - signed operand M, captured on accepted start
//   multiplier      - signed operand Q, captured on accepted start
//   ready/busy/done - IDLE / CALC / DONE state decodes (done is a one-cycle pulse)
//   product         - signed 2N-bit result, valid from done until the next accepted start
module booth_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N:0]    acc;
  logic [N-1:0]  q;
  logic          q_1;
  logic [N-1:0]  m;
  logic [CW-1:0] cnt;

  logic [N:0]    m_ext;
  logic [N:0]    addend;
  logic          cin;
  logic [N:0]    sum;
  logic [N:0]    acc_sh;
  logic [N-1:0]  q_sh;
  logic          last_iter;
  logic          load;

  // Booth step: add/subtract feeds an adder in the upstream stage's style,
  // where subtract is acc + ~M with carry-in 1. The accumulator is one bit
  // wider than the operand so that M = -2^(N-1) cannot overflow it.
  always_comb begin
    m_ext  = {m[N-1], m};
    addend = '0;
    cin    = 1'b0;
    case ({q[0], q_1})
      2'b01: begin
        addend = m_ext;
        cin    = 1'b0;
      end
      2'b10: begin
        addend = ~m_ext;
        cin    = 1'b1;
      end
      default: begin
        addend = '0;
        cin    = 1'b0;
      end
    endcase
    sum    = acc + addend + {{N{1'b0}}, cin};
    // Arithmetic shift right of {acc, q, q_1}, replicating the accumulator MSB.
    acc_sh = {sum[N], sum[N:1]};
    q_sh   = {sum[0], q[N-1:1]};
  end

  assign last_iter = (cnt == CW'(1));
  assign load      = (state == S_IDLE) && start;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (last_iter) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      m       <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      acc     <= '0;
      q       <= multiplier;
      q_1     <= 1'b0;
      m       <= multiplicand;
      cnt     <= CW'(N);
      product <= '0;
    end else if (state == S_CALC) begin
      acc <= acc_sh;
      q   <= q_sh;
      q_1 <= q[0];
      cnt <= cnt - CW'(1);
      // The counter hits zero on this edge: capture the shifted result directly.
      if (last_iter) product <= {acc_sh[N-1:0], q_sh};
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed self-checking bench for booth_multiplier with N = 8.
// Drives inputs on the falling edge, samples outputs on the falling edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_booth_multiplier;

  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int n_checks = 0;
  int n_pass   = 0;

  booth_multiplier #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One multiply from IDLE. Optionally pulses a second start (5 x 3) during
  // CALC cycle 3, which must be ignored.
  task automatic run_mul(input string tag, input logic [7:0] mv, input logic [7:0] qv,
                         input logic [15:0] exp, input bit inject);
    int lat;
    int nbusy;
    lat   = 0;
    nbusy = 0;
    @(negedge clk);
    multiplicand = mv;
    multiplier   = qv;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = 8'($urandom);
    multiplier   = 8'($urandom);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = i;
        break;
      end
      if (inject && i == 3) begin
        multiplicand = 8'd5;
        multiplier   = 8'd3;
        start        = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, "_done_cycle"}, lat, 9);
    check({tag, "_busy_cycles"}, nbusy, 8);
    check({tag, "_product"}, product, exp);
    @(negedge clk);
    check({tag, "_done_width"}, done, 1'b0);
    check({tag, "_ready_back"}, ready, 1'b1);
  endtask

  initial begin
    int seen_done;
    int gap;
    int t1;
    int t2;

    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    // Reset state while rst is held, before any clock edge.
    #2;
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_product", product, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Mixed sign, extremes, zero/identity.
    run_mul("mix_123_m80", 8'd123, -8'sd80, 16'hD990, 1'b0);
    run_mul("mix_m12_53", -8'sd12, 8'd53, 16'hFD84, 1'b0);
    run_mul("ext_m128_m128", 8'h80, 8'h80, 16'h4000, 1'b0);
    run_mul("ext_127_127", 8'd127, 8'd127, 16'h3F01, 1'b0);
    run_mul("ext_m128_127", 8'h80, 8'd127, 16'hC080, 1'b0);
    run_mul("zero_0_m1", 8'd0, 8'hFF, 16'h0000, 1'b0);
    run_mul("ident_m1_1", 8'hFF, 8'd1, 16'hFFFF, 1'b0);

    // Handshake: start pulsed during CALC is dropped.
    run_mul("hs_8_3", 8'd8, 8'd3, 16'h0018, 1'b1);
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("hs_no_queued_op", seen_done, 0);
    check("hs_product_hold", product, 16'h0018);

    // Asynchronous reset in IDLE clears the held product immediately.
    #1;
    rst = 1'b1;
    #1;
    check("rst_idle_product", product, 16'h0000);
    check("rst_idle_ready", ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-operation: abort in CALC cycle 4.
    @(negedge clk);
    multiplicand = 8'd123;
    multiplier   = -8'sd80;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_ready", ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_product", product, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort_no_done", seen_done, 0);
    check("abort_product_after", product, 16'h0000);
    run_mul("after_abort_2_1", 8'd2, 8'd1, 16'h0002, 1'b0);

    // Start held high: back-to-back operations every N+2 cycles.
    @(negedge clk);
    multiplicand = 8'd3;
    multiplier   = 8'hFE;
    start        = 1'b1;
    t1 = -1;
    t2 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        check("b2b_product", product, 16'hFFFA);
        if (t1 < 0) begin
          t1 = i;
        end else begin
          t2 = i;
          start = 1'b0;
          break;
        end
      end
    end
    gap = (t1 >= 0 && t2 >= 0) ? (t2 - t1) : -1;
    check("b2b_spacing", gap, N + 2);
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
